// File: rtl/return_addr_stack.sv
// return_addr_stack: parametrised return-address stack predicting RET targets for nested CALLs
// Ports: clk/reset (async, active-low); push+push_addr on CALL, pop on RET, flush drops all
// entries, clr_err clears sticky flags; top_addr/empty/full/count expose stack state;
// overflow/underflow are sticky error flags.
module return_addr_stack #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wp_q, wp_d, wp_inc, wp_dec;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              repl, pushing, popping;
    always_comb begin
        wp_inc  = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
        wp_dec  = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - 1'b1;
        empty   = count_q == '0;
        full    = count_q == CNT_W'(DEPTH);
        // push&pop on a non-empty stack rewrites the top entry in place
        repl    = ~flush & push & pop & ~empty;
        pushing = ~flush & push & ~repl & (~full | (OVF_MODE == 0));
        popping = ~flush & pop & ~push & ~empty;
        wp_d    = flush ? '0 : pushing ? wp_inc : popping ? wp_dec : wp_q;
        count_d = flush ? '0 : (pushing & ~full) ? count_q + 1'b1 :
                  popping ? count_q - 1'b1 : count_q;
        ovf_d   = (~flush & push & ~repl & full) | (ovf_q & ~clr_err);
        unf_d   = (~flush & pop & empty) | (unf_q & ~clr_err);
        mem_d   = mem_q;
        if (repl | pushing) mem_d[repl ? wp_dec : wp_q] = push_addr;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    assign top_addr  = empty ? '0 : mem_q[wp_dec];
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: table-driven, directed and randomized checks of three stack configurations
module tb_return_addr_stack;
    logic        clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [15:0] push_addr = '0;
    logic [15:0] top [3];
    logic        emp [3], ful [3], ovf [3], unf [3];
    logic [3:0]  cnt8;
    logic [2:0]  cntw, cntd;
    logic [3:0]  cnt [3];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    assign cnt[0] = cnt8;
    assign cnt[1] = {1'b0, cntw};
    assign cnt[2] = {1'b0, cntd};
    return_addr_stack #(.ADDR_W(16), .DEPTH(8), .OVF_MODE(0)) u8 (
        .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop), .flush(flush),
        .clr_err(clr_err), .top_addr(top[0]), .empty(emp[0]), .full(ful[0]), .count(cnt8),
        .overflow(ovf[0]), .underflow(unf[0]));
    return_addr_stack #(.ADDR_W(16), .DEPTH(4), .OVF_MODE(0)) uw (
        .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop), .flush(flush),
        .clr_err(clr_err), .top_addr(top[1]), .empty(emp[1]), .full(ful[1]), .count(cntw),
        .overflow(ovf[1]), .underflow(unf[1]));
    return_addr_stack #(.ADDR_W(16), .DEPTH(4), .OVF_MODE(1)) ud (
        .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop), .flush(flush),
        .clr_err(clr_err), .top_addr(top[2]), .empty(emp[2]), .full(ful[2]), .count(cntd),
        .overflow(ovf[2]), .underflow(unf[2]));

    // reference: m[i][0..mc-1] holds entries oldest to newest
    int          dep [3] = '{8, 4, 4};
    bit          drp [3] = '{0, 0, 1};
    logic [15:0] m [3][64];
    int          mc [3];
    bit          mo [3], mu [3];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mo[i] = 0;
            mu[i] = 0;
        end
    endfunction

    function automatic void model_step(bit ps, logic [15:0] a, bit pp, bit fl, bit cl);
        for (int i = 0; i < 3; i++) begin
            bit so, su;
            so = 0;
            su = 0;
            if (fl) mc[i] = 0;
            else if (ps && pp && mc[i] > 0) m[i][mc[i]-1] = a;
            else if (ps) begin
                su = pp;
                if (mc[i] < dep[i]) begin
                    m[i][mc[i]] = a;
                    mc[i]++;
                end else begin
                    so = 1;
                    if (!drp[i]) begin
                        for (int k = 0; k < dep[i] - 1; k++) m[i][k] = m[i][k+1];
                        m[i][dep[i]-1] = a;
                    end
                end
            end else if (pp) begin
                if (mc[i] > 0) mc[i]--;
                else su = 1;
            end
            mo[i] = so | (mo[i] & !cl);
            mu[i] = su | (mu[i] & !cl);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m_top%0d", i), 32'(top[i]), 32'(mc[i] > 0 ? m[i][mc[i]-1] : 16'h0));
            chk($sformatf("m_cnt%0d", i), 32'(cnt[i]), 32'(mc[i]));
            chk($sformatf("m_empty%0d", i), 32'(emp[i]), 32'(mc[i] == 0));
            chk($sformatf("m_full%0d", i), 32'(ful[i]), 32'(mc[i] == dep[i]));
            chk($sformatf("m_ovf%0d", i), 32'(ovf[i]), 32'(mo[i]));
            chk($sformatf("m_unf%0d", i), 32'(unf[i]), 32'(mu[i]));
        end
    endtask

    task automatic cyc(input bit ps, input logic [15:0] a, input bit pp, input bit fl, input bit cl);
        push = ps;
        push_addr = a;
        pop = pp;
        flush = fl;
        clr_err = cl;
        @(posedge clk);
        model_step(ps, a, pp, fl, cl);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
        clr_err = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        bit rst; bit ps; logic [15:0] a; bit pp; bit fl; bit cl;
        int sel; logic [15:0] top; int cnt; bit full; bit ovf; bit unf;
    } vec_t;
    vec_t tv[$];

    function automatic void v(bit rst, bit ps, logic [15:0] a, bit pp, bit fl, bit cl,
                              int sel, logic [15:0] t, int c, bit f, bit o, bit u);
        tv.push_back('{rst, ps, a, pp, fl, cl, sel, t, c, f, o, u});
    endfunction

    initial begin
        // nested call/return, DEPTH=8
        v(1,0,0,0,0,0, 0, 16'h0,0,0,0,0);
        v(0,1,16'h0003,0,0,0, 0, 16'h0003,1,0,0,0);
        v(0,1,16'h0010,0,0,0, 0, 16'h0010,2,0,0,0);
        v(0,1,16'h0020,0,0,0, 0, 16'h0020,3,0,0,0);
        v(0,0,0,1,0,0, 0, 16'h0010,2,0,0,0);
        v(0,0,0,1,0,0, 0, 16'h0003,1,0,0,0);
        v(0,0,0,1,0,0, 0, 16'h0000,0,0,0,0);
        // overflow wrap, DEPTH=4
        v(1,0,0,0,0,0, 1, 16'h0,0,0,0,0);
        v(0,1,16'h1,0,0,0, 1, 16'h1,1,0,0,0);
        v(0,1,16'h2,0,0,0, 1, 16'h2,2,0,0,0);
        v(0,1,16'h3,0,0,0, 1, 16'h3,3,0,0,0);
        v(0,1,16'h4,0,0,0, 1, 16'h4,4,1,0,0);
        v(0,1,16'h5,0,0,0, 1, 16'h5,4,1,1,0);
        v(0,0,0,1,0,0, 1, 16'h4,3,0,1,0);
        v(0,0,0,1,0,0, 1, 16'h3,2,0,1,0);
        v(0,0,0,1,0,0, 1, 16'h2,1,0,1,0);
        v(0,0,0,1,0,0, 1, 16'h0,0,0,1,0);
        // overflow drop, DEPTH=4
        v(1,0,0,0,0,0, 2, 16'h0,0,0,0,0);
        v(0,1,16'h1,0,0,0, 2, 16'h1,1,0,0,0);
        v(0,1,16'h2,0,0,0, 2, 16'h2,2,0,0,0);
        v(0,1,16'h3,0,0,0, 2, 16'h3,3,0,0,0);
        v(0,1,16'h4,0,0,0, 2, 16'h4,4,1,0,0);
        v(0,1,16'h5,0,0,0, 2, 16'h4,4,1,1,0);
        v(0,0,0,1,0,0, 2, 16'h3,3,0,1,0);
        v(0,0,0,1,0,0, 2, 16'h2,2,0,1,0);
        v(0,0,0,1,0,0, 2, 16'h1,1,0,1,0);
        v(0,0,0,1,0,0, 2, 16'h0,0,0,1,0);
        // underflow and sticky-flag clearing
        v(1,0,0,0,0,0, 0, 16'h0,0,0,0,0);
        v(0,0,0,1,0,0, 0, 16'h0,0,0,0,1);
        v(0,0,0,0,0,1, 0, 16'h0,0,0,0,0);
        v(0,0,0,1,0,1, 0, 16'h0,0,0,0,1);
        // replace then flush; underflow survives the flush
        v(0,1,16'h0003,0,0,0, 0, 16'h0003,1,0,0,1);
        v(0,1,16'h0007,1,0,0, 0, 16'h0007,1,0,0,1);
        v(0,1,16'h0009,0,1,0, 0, 16'h0000,0,0,0,1);

        foreach (tv[j]) begin
            int s;
            s = tv[j].sel;
            if (tv[j].rst) do_reset();
            else cyc(tv[j].ps, tv[j].a, tv[j].pp, tv[j].fl, tv[j].cl);
            chk($sformatf("v%0d_top", j), 32'(top[s]), 32'(tv[j].top));
            chk($sformatf("v%0d_cnt", j), 32'(cnt[s]), 32'(tv[j].cnt));
            chk($sformatf("v%0d_empty", j), 32'(emp[s]), 32'(tv[j].cnt == 0));
            chk($sformatf("v%0d_full", j), 32'(ful[s]), 32'(tv[j].full));
            chk($sformatf("v%0d_ovf", j), 32'(ovf[s]), 32'(tv[j].ovf));
            chk($sformatf("v%0d_unf", j), 32'(unf[s]), 32'(tv[j].unf));
            check_model();
        end

        // async reset between clock edges
        do_reset();
        cyc(0, 16'h0, 1, 0, 0);
        cyc(1, 16'h0011, 0, 0, 0);
        cyc(1, 16'h0022, 0, 0, 0);
        cyc(1, 16'h0033, 0, 0, 0);
        chk("pre_rst_cnt", 32'(cnt[0]), 32'd3);
        chk("pre_rst_unf", 32'(unf[0]), 32'd1);
        #3;
        reset = 1'b0;
        push = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst_top%0d", i), 32'(top[i]), 32'h0);
            chk($sformatf("arst_cnt%0d", i), 32'(cnt[i]), 32'h0);
            chk($sformatf("arst_empty%0d", i), 32'(emp[i]), 32'h1);
            chk($sformatf("arst_full%0d", i), 32'(ful[i]), 32'h0);
            chk($sformatf("arst_ovf%0d", i), 32'(ovf[i]), 32'h0);
            chk($sformatf("arst_unf%0d", i), 32'(unf[i]), 32'h0);
        end
        model_reset();
        #2;
        reset = 1'b1;
        cyc(1, 16'h0042, 0, 0, 0);
        chk("post_rst_top", 32'(top[0]), 32'h42);
        chk("post_rst_cnt", 32'(cnt[0]), 32'h1);
        check_model();

        // randomized traffic against the reference
        do_reset();
        check_model();
        repeat (3000) begin
            bit ps, pp, fl, cl;
            ps = $urandom_range(0, 99) < 50;
            pp = $urandom_range(0, 99) < 40;
            fl = $urandom_range(0, 99) < 3;
            cl = $urandom_range(0, 99) < 5;
            cyc(ps, 16'($urandom), pp, fl, cl);
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
